// File: rtl/axis_adder.sv
// Handshaked WIDTH-bit adder/subtractor feeding a DEPTH-entry result FIFO.
// Define AXIS_ADDER_OVERFLOW_EN to add a per-entry signed overflow flag and the overflow_out port.
module axis_adder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             sub_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             valid_out,
    input  logic             ready_in
`ifdef AXIS_ADDER_OVERFLOW_EN
    ,
    output logic             overflow_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef AXIS_ADDER_OVERFLOW_EN
    localparam int ENTRY_W = WIDTH + 2;
`else
    localparam int ENTRY_W = WIDTH + 1;
`endif

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               ready_out_reg;
    logic               valid_out_reg;

    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     result;
    logic [ENTRY_W-1:0] entry_next;
    logic [ENTRY_W-1:0] head;

    assign push = valid_in && ready_out_reg;
    assign pop  = valid_out_reg && ready_in;

    // Subtract is A + ~B + 1, so carry-out of 1 means no borrow.
    assign b_eff  = sub_in ? ~b_in : b_in;
    assign result = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_in};

`ifdef AXIS_ADDER_OVERFLOW_EN
    logic overflow;
    // Same rule covers both ops once B has been conditionally inverted.
    assign overflow   = (a_in[WIDTH-1] == b_eff[WIDTH-1]) && (result[WIDTH-1] != a_in[WIDTH-1]);
    assign entry_next = {overflow, result};
`else
    assign entry_next = result;
`endif

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            ready_out_reg <= 1'b0;
            valid_out_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= entry_next;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg     <= count_next;
            ready_out_reg <= (count_next < CNT_W'(DEPTH));
            valid_out_reg <= (count_next != '0);
        end
    end

    assign head      = mem_reg[rd_ptr_reg];
    assign sum_out   = head[WIDTH-1:0];
    assign carry_out = head[WIDTH];
    assign ready_out = ready_out_reg;
    assign valid_out = valid_out_reg;
`ifdef AXIS_ADDER_OVERFLOW_EN
    assign overflow_out = head[WIDTH+1];
`endif

endmodule

// File: tb/tb_axis_adder.sv
// Directed and scoreboarded checks for axis_adder at WIDTH=8, DEPTH=2.
module tb_axis_adder;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] a_in = '0;
    logic [WIDTH-1:0] b_in = '0;
    logic             sub_in = 1'b0;
    logic             valid_in = 1'b0;
    logic             ready_in = 1'b0;
    logic             ready_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;
    logic             valid_out;
`ifdef AXIS_ADDER_OVERFLOW_EN
    logic             overflow_out;
`endif

    always #5 clk = ~clk;

    axis_adder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .sub_in    (sub_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .sum_out   (sum_out),
        .carry_out (carry_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
`ifdef AXIS_ADDER_OVERFLOW_EN
        ,
        .overflow_out (overflow_out)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub);
        a_in     = a;
        b_in     = b;
        sub_in   = sub;
        valid_in = 1'b1;
        check_eq("send_ready", 32'(ready_out), 1);
        step();
        valid_in = 1'b0;
        $display("sent a=0x%02h b=0x%02h sub=%0d -> sum=0x%02h carry=%0d", a, b, sub, sum_out, carry_out);
    endtask

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        exp_t e;
        int   sa = $signed(a);
        int   sb = $signed(b);
        int   r;
        if (!sub) begin
            e.s = a + b;
            e.c = (int'(a) + int'(b)) > 255;
            r   = sa + sb;
        end else begin
            e.s = a - b;
            e.c = (a >= b);
            r   = sa - sb;
        end
        e.o = (r > 127) || (r < -128);
        return e;
    endfunction

    bit         sb_en = 1'b0;
    int         n_acc = 0;
    int         n_out = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_sum;
    logic       prev_carry;

    // Sampled on the falling edge: values here are what the next rising edge will see.
    always @(negedge clk) begin
        if (sb_en && rst) begin
            if (prev_stall && valid_out) begin
                check_eq("hold_sum", 32'(sum_out), 32'(prev_sum));
                check_eq("hold_carry", 32'(carry_out), 32'(prev_carry));
            end
            if (valid_out && ready_in) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(sb_q.size()), 1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_eq("sb_sum", 32'(sum_out), 32'(e.s));
                    check_eq("sb_carry", 32'(carry_out), 32'(e.c));
`ifdef AXIS_ADDER_OVERFLOW_EN
                    check_eq("sb_ovf", 32'(overflow_out), 32'(e.o));
`endif
                    $display("beat %0d out: sum=0x%02h carry=%0d", n_out, sum_out, carry_out);
                    n_out++;
                end
            end
            if (valid_in && ready_out) begin
                sb_q.push_back(model(a_in, b_in, sub_in));
                n_acc++;
            end
            prev_stall = valid_out && !ready_in;
            prev_sum   = sum_out;
            prev_carry = carry_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;

        // Reset state and first add
        ready_in = 1'b1;
        #12;
        check_eq("rst_ready", 32'(ready_out), 0);
        check_eq("rst_valid", 32'(valid_out), 0);
        check_eq("rst_sum", 32'(sum_out), 0);
        check_eq("rst_carry", 32'(carry_out), 0);
`ifdef AXIS_ADDER_OVERFLOW_EN
        check_eq("rst_ovf", 32'(overflow_out), 0);
`endif
        rst = 1'b1;
        step();
        check_eq("post_rst_ready", 32'(ready_out), 1);
        check_eq("post_rst_valid", 32'(valid_out), 0);

        send(8'h7F, 8'h01, 1'b0);
        check_eq("add_valid", 32'(valid_out), 1);
        check_eq("add_sum", 32'(sum_out), 'h80);
        check_eq("add_carry", 32'(carry_out), 0);
`ifdef AXIS_ADDER_OVERFLOW_EN
        check_eq("add_ovf", 32'(overflow_out), 1);
`endif
        step();
        check_eq("add_popped", 32'(valid_out), 0);

        // Carry and borrow
        send(8'hFF, 8'h01, 1'b0);
        check_eq("carry_sum", 32'(sum_out), 'h00);
        check_eq("carry_carry", 32'(carry_out), 1);
`ifdef AXIS_ADDER_OVERFLOW_EN
        check_eq("carry_ovf", 32'(overflow_out), 0);
`endif
        step();
        send(8'h03, 8'h05, 1'b1);
        check_eq("borrow_sum", 32'(sum_out), 'hFE);
        check_eq("borrow_carry", 32'(carry_out), 0);
`ifdef AXIS_ADDER_OVERFLOW_EN
        check_eq("borrow_ovf", 32'(overflow_out), 0);
`endif
        step();

        // Back-pressure: exactly DEPTH beats accepted
        ready_in = 1'b0;
        valid_in = 1'b1;
        a_in     = 8'h10;
        b_in     = 8'h00;
        sub_in   = 1'b0;
        check_eq("bp_ready0", 32'(ready_out), 1);
        step();
        check_eq("bp_ready1", 32'(ready_out), 1);
        a_in = 8'h11;
        step();
        check_eq("bp_full", 32'(ready_out), 0);
        check_eq("bp_valid", 32'(valid_out), 1);
        a_in = 8'h12;
        step();
        check_eq("bp_still_full", 32'(ready_out), 0);
        check_eq("bp_hold", 32'(sum_out), 'h10);
        valid_in = 1'b0;
        ready_in = 1'b1;
        step();
        check_eq("bp_ready_ret", 32'(ready_out), 1);
        check_eq("bp_second", 32'(sum_out), 'h11);
        step();
        check_eq("bp_empty", 32'(valid_out), 0);

        // Streaming: one result per cycle
        for (int i = 0; i < 16; i++) begin
            a_in     = 8'(i);
            b_in     = 8'(2 * i);
            sub_in   = 1'b0;
            valid_in = 1'b1;
            step();
            check_eq("stream_sum", 32'(sum_out), (3 * i) & 'hFF);
            check_eq("stream_valid", 32'(valid_out), 1);
            check_eq("stream_ready", 32'(ready_out), 1);
            $display("stream %0d: sum=0x%02h", i, sum_out);
        end
        valid_in = 1'b0;
        step();
        check_eq("stream_drained", 32'(valid_out), 0);

        // Random stall against scoreboard
        sb_en = 1'b1;
        cyc   = 0;
        while (n_acc < 1000 && cyc < 10000) begin
            valid_in = 1'($urandom_range(0, 1));
            ready_in = ($urandom_range(0, 3) != 0);
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            sub_in   = 1'($urandom_range(0, 1));
            step();
            cyc++;
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (DEPTH + 2) step();
        check_eq("rand_accepted", 32'(n_acc), 1000);
        check_eq("rand_delivered", 32'(n_out), 1000);
        check_eq("rand_drained", 32'(sb_q.size()), 0);
        sb_en = 1'b0;

        // Async reset with the FIFO half full
        ready_in = 1'b0;
        send(8'h40, 8'h01, 1'b0);
        check_eq("pre_rst_valid", 32'(valid_out), 1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_valid", 32'(valid_out), 0);
        check_eq("async_ready", 32'(ready_out), 0);
        check_eq("async_sum", 32'(sum_out), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        step();
        check_eq("rel_ready", 32'(ready_out), 1);
        check_eq("rel_valid", 32'(valid_out), 0);
        send(8'h21, 8'h02, 1'b0);
        check_eq("rel_first_valid", 32'(valid_out), 1);
        check_eq("rel_first_sum", 32'(sum_out), 'h23);
        check_eq("rel_first_carry", 32'(carry_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
